spi_sample_responder: RTL and testbench

//  SPI peripheral (responder) end of the microphone sample link: holds 16-bit samples in a small FIFO
//  and shifts them out MSB-first on MISO while the SPI controller drives CS_b low and toggles sclk.

---
 rtl/spi_mic_pkg.sv | 15 +
 rtl/sample_fifo.sv | 54 +++++
 rtl/spi_sample_responder.sv | 144 ++++++++++++++
 tb/tb_spi_sample_responder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_mic_pkg.sv
// Shared types and defaults for the microphone sample link responder.
package spi_mic_pkg;

  localparam int              SAMPLE_W_DEF   = 16;
  localparam int              FIFO_DEPTH_DEF = 8;
  localparam logic [15:0]     IDLE_WORD_DEF  = 16'h0000;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } spi_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO with a separate occupancy counter; pointers wrap modulo DEPTH.
module sample_fifo #(
  parameter int  W     = 16,
  parameter int  DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             PCLK,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     rdata,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: storage has no reset; only pointers and level define validity, so clearing the array buys nothing.
  always_ff @(posedge PCLK) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge PCLK or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/spi_sample_responder.sv
// SPI mode-0 responder: serialises queued samples MSB-first on MISO while CS_b is low.
// sclk and CS_b are asynchronous and oversampled on PCLK through 2-flop synchronizers.
module spi_sample_responder
  import spi_mic_pkg::*;
#(
  parameter int                  SAMPLE_W   = SAMPLE_W_DEF,
  parameter int                  FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter logic [SAMPLE_W-1:0] IDLE_WORD  = SAMPLE_W'(IDLE_WORD_DEF),
  localparam int                 LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                PCLK,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample_data,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic                CS_b,
  input  logic                sclk,
  output logic                MISO,
  output logic [LVL_W-1:0]    fifo_level,
  output logic                frame_done,
  output logic                underrun,
  output logic                frame_abort
);

  localparam int               CNT_W    = $clog2(SAMPLE_W) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SAMPLE_W - 1);

  logic                cs_s1, cs_s2, cs_d;
  logic                sclk_s1, sclk_s2, sclk_d;
  logic                cs_fall, cs_rise, sclk_rise, sclk_fall;
  logic [SAMPLE_W-1:0] fifo_head;
  logic [SAMPLE_W-1:0] load_word;
  logic                fifo_full, fifo_empty, fifo_pop;
  spi_state_t          state;
  logic [SAMPLE_W-1:0] shreg;
  logic [CNT_W-1:0]    bit_cnt;
  logic                seen_rise;

  sample_fifo #(
    .W     (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .PCLK  (PCLK),
    .reset (reset),
    .push  (sample_valid),
    .pop   (fifo_pop),
    .wdata (sample_data),
    .rdata (fifo_head),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign sample_ready = !fifo_full;
  // The word is consumed on entering LOAD even if the frame is then aborted.
  assign fifo_pop     = (state == LOAD);
  assign load_word    = fifo_empty ? IDLE_WORD : fifo_head;

  // CS_b idles high and sclk idles low, so the synchronizers reset to those levels.
  always_ff @(posedge PCLK or posedge reset) begin
    if (reset) begin
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_d    <= 1'b1;
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_d  <= 1'b0;
    end else begin
      cs_s1   <= CS_b;
      cs_s2   <= cs_s1;
      cs_d    <= cs_s2;
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
    end
  end

  assign cs_fall   =  cs_d   && !cs_s2;
  assign cs_rise   = !cs_d   &&  cs_s2;
  assign sclk_rise = !sclk_d &&  sclk_s2;
  assign sclk_fall =  sclk_d && !sclk_s2;

  always_ff @(posedge PCLK or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      seen_rise   <= 1'b0;
      MISO        <= 1'b0;
      frame_done  <= 1'b0;
      underrun    <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      underrun    <= 1'b0;
      frame_abort <= 1'b0;
      unique case (state)
        IDLE: begin
          MISO <= 1'b0;
          if (cs_fall) state <= LOAD;
        end
        LOAD: begin
          underrun <= fifo_empty;
          if (cs_rise) begin
            frame_abort <= 1'b1;
            MISO        <= 1'b0;
            state       <= IDLE;
          end else begin
            shreg     <= load_word;
            MISO      <= load_word[SAMPLE_W-1];
            bit_cnt   <= '0;
            seen_rise <= 1'b0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            frame_abort <= 1'b1;
            MISO        <= 1'b0;
            state       <= IDLE;
          end else if (sclk_rise) begin
            // Rising edges are the controller's sample points, so they count the bits.
            seen_rise <= 1'b1;
            bit_cnt   <= bit_cnt + CNT_W'(1);
            if (bit_cnt == LAST_BIT) begin
              frame_done <= 1'b1;
              MISO       <= 1'b0;
              state      <= DONE;
            end
          end else if (sclk_fall && seen_rise) begin
            // A fall before any rise is a select-time glitch, not a shift point.
            shreg <= shreg << 1;
            MISO  <= shreg[SAMPLE_W-2];
          end
        end
        DONE: begin
          MISO <= 1'b0;
          if (cs_rise) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_sample_responder.sv
// Bench for spi_sample_responder: directed frame table, randomized frames against a queue model,
// and hand-written reset/same-cycle-push sequences.
module tb_spi_sample_responder;

  logic        PCLK = 1'b0;
  logic        reset;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic        CS_b;
  logic        sclk;
  logic        MISO;
  logic [3:0]  fifo_level;
  logic        frame_done;
  logic        underrun;
  logic        frame_abort;

  spi_sample_responder dut (
    .PCLK         (PCLK),
    .reset        (reset),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .CS_b         (CS_b),
    .sclk         (sclk),
    .MISO         (MISO),
    .fifo_level   (fifo_level),
    .frame_done   (frame_done),
    .underrun     (underrun),
    .frame_abort  (frame_abort)
  );

  always #5 PCLK = ~PCLK;

  int errors = 0;
  int checks = 0;

  // Reference model: the FIFO is just a queue of words, capacity 8.
  logic [15:0] q[$];

  int done_seen  = 0;
  int und_seen   = 0;
  int abort_seen = 0;

  always @(negedge PCLK) begin
    if (frame_done)  done_seen++;
    if (underrun)    und_seen++;
    if (frame_abort) abort_seen++;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [15:0] w);
    @(negedge PCLK);
    check("sample_ready", 32'(sample_ready), 32'(q.size() != 8));
    sample_data  = w;
    sample_valid = 1'b1;
    if (q.size() != 8) q.push_back(w);
    @(negedge PCLK);
    sample_valid = 1'b0;
    check("push_level", 32'(fifo_level), 32'(q.size()));
  endtask

  // Runs one mode-0 frame of nbits clocks at PCLK/10; the model predicts the word and underrun.
  task automatic run_frame(input int nbits, input bit push_at_load, input logic [15:0] pword,
                           output logic [15:0] bits, output int d_done, output int d_und,
                           output int d_abort, output logic [15:0] exp_bits, output bit exp_und);
    int          d0, u0, a0;
    bit          accept;
    logic [15:0] exp_word;
    d0 = done_seen; u0 = und_seen; a0 = abort_seen;
    bits = '0;
    accept = push_at_load && (q.size() != 8);
    exp_und = (q.size() == 0);
    exp_word = exp_und ? 16'h0000 : q.pop_front();
    if (accept) q.push_back(pword);
    exp_bits = exp_word >> (16 - nbits);
    @(negedge PCLK);
    CS_b = 1'b0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    if (push_at_load) begin
      sample_data  = pword;
      sample_valid = 1'b1;
    end
    @(negedge PCLK);
    sample_valid = 1'b0;
    if (push_at_load) check("load_push_level", 32'(fifo_level), 32'(q.size()));
    repeat (2) @(negedge PCLK);
    for (int i = 0; i < nbits; i++) begin
      bits = {bits[14:0], MISO};
      sclk = 1'b1;
      repeat (5) @(negedge PCLK);
      sclk = 1'b0;
      repeat (5) @(negedge PCLK);
    end
    CS_b = 1'b1;
    repeat (6) @(negedge PCLK);
    d_done  = done_seen - d0;
    d_und   = und_seen - u0;
    d_abort = abort_seen - a0;
  endtask

  typedef struct {
    int          n_push;
    logic [15:0] base;
    int          nbits;
    logic [15:0] exp_bits;
    int          exp_done;
    int          exp_und;
    int          exp_abort;
    int          exp_level;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [15:0] bits, eb;
    int          dd, du, da, d0, a0, nb, np;
    bit          eu, pal;

    vecs[0] = '{1, 16'hA5C3, 16, 16'hA5C3, 1, 0, 0, 0};
    vecs[1] = '{0, 16'h0000, 16, 16'h0000, 1, 1, 0, 0};
    vecs[2] = '{2, 16'hFFFF, 5,  16'h001F, 0, 0, 1, 1};
    vecs[3] = '{0, 16'h0000, 16, 16'hFFFE, 1, 0, 0, 0};
    vecs[4] = '{9, 16'h1000, 16, 16'h1000, 1, 0, 0, 7};

    reset = 1'b1; CS_b = 1'b1; sclk = 1'b0; sample_valid = 1'b0; sample_data = '0;
    repeat (3) @(negedge PCLK);
    check("rst_miso", 32'(MISO), 32'd0);
    check("rst_ready", 32'(sample_ready), 32'd1);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_pulses", {29'd0, frame_done, underrun, frame_abort}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge PCLK);

    // Directed frames: words pushed are base ^ i.
    foreach (vecs[k]) begin
      for (int i = 0; i < vecs[k].n_push; i++) push_word(vecs[k].base ^ 16'(i));
      run_frame(vecs[k].nbits, 1'b0, 16'h0, bits, dd, du, da, eb, eu);
      check($sformatf("vec%0d_bits", k), 32'(bits), 32'(vecs[k].exp_bits));
      check($sformatf("vec%0d_done", k), 32'(dd), 32'(vecs[k].exp_done));
      check($sformatf("vec%0d_underrun", k), 32'(du), 32'(vecs[k].exp_und));
      check($sformatf("vec%0d_abort", k), 32'(da), 32'(vecs[k].exp_abort));
      check($sformatf("vec%0d_level", k), 32'(fifo_level), 32'(vecs[k].exp_level));
      check($sformatf("vec%0d_ready", k), 32'(sample_ready), 32'(vecs[k].exp_level != 8));
    end

    // Randomized frames against the queue model.
    for (int it = 0; it < 16; it++) begin
      np = $urandom_range(0, 3);
      for (int i = 0; i < np; i++) push_word(16'($urandom));
      nb  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 16;
      pal = ($urandom_range(0, 3) == 0);
      run_frame(nb, pal, 16'($urandom), bits, dd, du, da, eb, eu);
      check($sformatf("rnd%0d_bits", it), 32'(bits), 32'(eb));
      check($sformatf("rnd%0d_done", it), 32'(dd), 32'(nb == 16));
      check($sformatf("rnd%0d_abort", it), 32'(da), 32'(nb != 16));
      check($sformatf("rnd%0d_underrun", it), 32'(du), 32'(eu));
      check($sformatf("rnd%0d_level", it), 32'(fifo_level), 32'(q.size()));
    end

    // Reset in the middle of SHIFT.
    push_word(16'hC0DE);
    push_word(16'h5A5A);
    @(negedge PCLK);
    CS_b = 1'b0;
    repeat (6) @(negedge PCLK);
    for (int i = 0; i < 3; i++) begin
      sclk = 1'b1; repeat (5) @(negedge PCLK);
      sclk = 1'b0; repeat (5) @(negedge PCLK);
    end
    sclk = 1'b1;
    repeat (2) @(negedge PCLK);
    d0 = done_seen; a0 = abort_seen;
    #2 reset = 1'b1;
    #1;
    check("midrst_miso", 32'(MISO), 32'd0);
    check("midrst_level", 32'(fifo_level), 32'd0);
    check("midrst_ready", 32'(sample_ready), 32'd1);
    CS_b = 1'b1; sclk = 1'b0;
    repeat (2) @(negedge PCLK);
    reset = 1'b0;
    q.delete();
    repeat (10) @(negedge PCLK);
    check("midrst_no_done", 32'(done_seen - d0), 32'd0);
    check("midrst_no_abort", 32'(abort_seen - a0), 32'd0);
    check("midrst_level_after", 32'(fifo_level), 32'd0);

    // Push lands on the same cycle as the LOAD pop with one word queued.
    push_word(16'hBEEF);
    run_frame(16, 1'b1, 16'h1357, bits, dd, du, da, eb, eu);
    check("samecyc_bits0", 32'(bits), 32'h0000BEEF);
    check("samecyc_level", 32'(fifo_level), 32'd1);
    run_frame(16, 1'b0, 16'h0, bits, dd, du, da, eb, eu);
    check("samecyc_bits1", 32'(bits), 32'h00001357);
    check("samecyc_done1", 32'(dd), 32'd1);
    check("samecyc_level_end", 32'(fifo_level), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
